// File: rtl/icache_pkg.sv
// Shared sizing, FSM encoding and address/tag helpers for the I-cache miss refill path.
package icache_pkg;

    localparam int OFFSET_SIZE    = 5;
    localparam int INDEX_SIZE     = 8;
    localparam int TAG_SIZE       = 64 - (OFFSET_SIZE + INDEX_SIZE);
    localparam int LINE_BYTES     = 2 ** OFFSET_SIZE;
    localparam int BUS_BYTES      = 8;
    localparam int BUS_W          = BUS_BYTES * 8;
    localparam int BEATS_PER_LINE = LINE_BYTES / BUS_BYTES;
    localparam int BEAT_W         = $clog2(BEATS_PER_LINE);
    localparam int TAG_VALID_BIT  = 0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        TAGWR,
        DONE
    } refill_state_e;

    function automatic logic [63:0] line_addr(input logic [TAG_SIZE-1:0]   tag,
                                              input logic [INDEX_SIZE-1:0] index);
        return {tag, index, {OFFSET_SIZE{1'b0}}};
    endfunction

    // Valid flag sits in the first (most significant) field of the tag entry.
    function automatic logic [TAG_SIZE:0] tag_entry(input logic [TAG_SIZE-1:0] tag);
        logic [TAG_SIZE:0] e;
        e                           = '0;
        e[TAG_SIZE - TAG_VALID_BIT] = 1'b1;
        e[TAG_SIZE-1:0]             = tag;
        return e;
    endfunction

endpackage

// File: rtl/icache_miss_refill_if.sv
// Miss request, memory read bus and cache write ports of the I-cache refill handler.
interface icache_miss_refill_if;
    import icache_pkg::*;

    logic                  isCacheMiss_i;
    logic [TAG_SIZE-1:0]   missTag_i;
    logic [INDEX_SIZE-1:0] missIndex_i;
    logic [OFFSET_SIZE-1:0] missOffset_i;
    logic                  memReq_o;
    logic [63:0]           memAddr_o;
    logic                  memAck_i;
    logic                  memDataValid_i;
    logic [BUS_W-1:0]      memData_i;
    logic                  instrWriteEnable_o;
    logic [INDEX_SIZE-1:0] instrWriteIndex_o;
    logic [BEAT_W-1:0]     instrWriteBeat_o;
    logic [BUS_W-1:0]      instrWriteData_o;
    logic                  tagWriteEnable_o;
    logic [INDEX_SIZE-1:0] tagWriteIndex_o;
    logic [TAG_SIZE:0]     tagWriteData_o;
    logic                  isCacheMissResolved_o;
    logic                  busy_o;

    // Environment side: fetch stage 2, memory port and cache arrays.
    modport master (
        output isCacheMiss_i, missTag_i, missIndex_i, missOffset_i,
        output memAck_i, memDataValid_i, memData_i,
        input  memReq_o, memAddr_o,
        input  instrWriteEnable_o, instrWriteIndex_o, instrWriteBeat_o, instrWriteData_o,
        input  tagWriteEnable_o, tagWriteIndex_o, tagWriteData_o,
        input  isCacheMissResolved_o, busy_o
    );

    // Refill handler side.
    modport slave (
        input  isCacheMiss_i, missTag_i, missIndex_i, missOffset_i,
        input  memAck_i, memDataValid_i, memData_i,
        output memReq_o, memAddr_o,
        output instrWriteEnable_o, instrWriteIndex_o, instrWriteBeat_o, instrWriteData_o,
        output tagWriteEnable_o, tagWriteIndex_o, tagWriteData_o,
        output isCacheMissResolved_o, busy_o
    );

endinterface

// File: rtl/refill_beat_counter.sv
// Beat slot counter for one line refill; wraps to zero exactly after the last beat.
module refill_beat_counter
    import icache_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              inc_i,
    output logic [BEAT_W-1:0] count_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] count_q, count_d;

    // A load coinciding with a beat accepts slot 0 and moves on to slot 1.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = inc_i ? BEAT_W'(1) : '0;
        end else if (inc_i) begin
            count_d = count_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == BEAT_W'(BEATS_PER_LINE - 1));

endmodule

// File: rtl/icache_miss_refill.sv
// I-cache miss handler: requests the missing line, streams beats into instruction memory,
// installs the tag after the last beat and pulses resolved to release fetch.
module icache_miss_refill
    import icache_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_i,
    icache_miss_refill_if.slave  bus
);

    refill_state_e         state_q, state_d;
    logic [TAG_SIZE-1:0]   miss_tag_q, miss_tag_d;
    logic [INDEX_SIZE-1:0] miss_index_q, miss_index_d;
    logic                  mem_req_q, mem_req_d;
    logic [63:0]           mem_addr_q, mem_addr_d;
    logic                  instr_we_q, instr_we_d;
    logic [INDEX_SIZE-1:0] instr_idx_q, instr_idx_d;
    logic [BEAT_W-1:0]     instr_beat_q, instr_beat_d;
    logic [BUS_W-1:0]      instr_data_q, instr_data_d;
    logic                  tag_we_q, tag_we_d;
    logic [INDEX_SIZE-1:0] tag_idx_q, tag_idx_d;
    logic [TAG_SIZE:0]     tag_data_q, tag_data_d;
    logic                  resolved_q, resolved_d;
    logic                  busy_q, busy_d;

    logic                  cnt_load, cnt_inc, cnt_last;
    logic [BEAT_W-1:0]     cnt;
    logic                  unused_offset;

    assign unused_offset = ^bus.missOffset_i;

    refill_beat_counter u_beat_cnt (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .load_i  (cnt_load),
        .inc_i   (cnt_inc),
        .count_o (cnt),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        miss_tag_d   = miss_tag_q;
        miss_index_d = miss_index_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        instr_we_d   = 1'b0;
        instr_idx_d  = '0;
        instr_beat_d = '0;
        instr_data_d = '0;
        tag_we_d     = 1'b0;
        tag_idx_d    = '0;
        tag_data_d   = '0;
        resolved_d   = 1'b0;
        cnt_load     = 1'b0;
        cnt_inc      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.isCacheMiss_i) begin
                    miss_tag_d   = bus.missTag_i;
                    miss_index_d = bus.missIndex_i;
                    mem_addr_d   = line_addr(bus.missTag_i, bus.missIndex_i);
                    mem_req_d    = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (bus.memAck_i) begin
                    mem_req_d  = 1'b0;
                    mem_addr_d = '0;
                    cnt_load   = 1'b1;
                    state_d    = FILL;
                    if (bus.memDataValid_i) begin
                        cnt_inc      = 1'b1;
                        instr_we_d   = 1'b1;
                        instr_idx_d  = miss_index_q;
                        instr_data_d = bus.memData_i;
                    end
                end
            end
            FILL: begin
                if (bus.memDataValid_i) begin
                    cnt_inc      = 1'b1;
                    instr_we_d   = 1'b1;
                    instr_idx_d  = miss_index_q;
                    instr_beat_d = cnt;
                    instr_data_d = bus.memData_i;
                    // Tag output is armed on the last-beat edge so it lands in the TAGWR cycle.
                    if (cnt_last) begin
                        tag_we_d   = 1'b1;
                        tag_idx_d  = miss_index_q;
                        tag_data_d = tag_entry(miss_tag_q);
                        state_d    = TAGWR;
                    end
                end
            end
            TAGWR: begin
                resolved_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            instr_we_q   <= 1'b0;
            instr_idx_q  <= '0;
            instr_beat_q <= '0;
            instr_data_q <= '0;
            tag_we_q     <= 1'b0;
            tag_idx_q    <= '0;
            tag_data_q   <= '0;
            resolved_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            instr_we_q   <= instr_we_d;
            instr_idx_q  <= instr_idx_d;
            instr_beat_q <= instr_beat_d;
            instr_data_q <= instr_data_d;
            tag_we_q     <= tag_we_d;
            tag_idx_q    <= tag_idx_d;
            tag_data_q   <= tag_data_d;
            resolved_q   <= resolved_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.memReq_o              = mem_req_q;
    assign bus.memAddr_o             = mem_addr_q;
    assign bus.instrWriteEnable_o    = instr_we_q;
    assign bus.instrWriteIndex_o     = instr_idx_q;
    assign bus.instrWriteBeat_o      = instr_beat_q;
    assign bus.instrWriteData_o      = instr_data_q;
    assign bus.tagWriteEnable_o      = tag_we_q;
    assign bus.tagWriteIndex_o       = tag_idx_q;
    assign bus.tagWriteData_o        = tag_data_q;
    assign bus.isCacheMissResolved_o = resolved_q;
    assign bus.busy_o                = busy_q;

endmodule
